// File: rtl/misr_compactor_pkg.sv
// Shared definitions for the LBIST response compactor: session FSM states and
// an elaboration-time geometry check.
package misr_compactor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Response bus must split into whole signature-width slices.
    function automatic bit geometry_ok(input int din_w, input int width);
        return (width >= 2) && (din_w >= width) && ((din_w % width) == 0);
    endfunction

endpackage

// File: rtl/misr_compactor_core.sv
// Signature register: folds the response bus into WIDTH bits and advances a
// Galois MISR step on each enabled cycle; load restores the seed.
module misr_compactor_core
    import misr_compactor_pkg::*;
#(
    parameter int               WIDTH = 24,
    parameter int               DIN_W = 48,
    parameter logic [WIDTH-1:0] POLY  = 24'h000087,
    parameter logic [WIDTH-1:0] SEED  = 24'd100,
    parameter bit               MODE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    localparam int SLICES = DIN_W / WIDTH;

    if (!geometry_ok(DIN_W, WIDTH)) begin : g_bad_geometry
        $error("misr_compactor_core: DIN_W (%0d) must be a multiple of WIDTH (%0d), WIDTH >= 2",
               DIN_W, WIDTH);
    end

    logic [WIDTH-1:0] sig_r;
    logic [WIDTH-1:0] fold_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] next_s;

    // Fold all slices of the response bus together.
    always_comb begin
        fold_s = {WIDTH{1'b0}};
        for (int j = 0; j < SLICES; j++) begin
            fold_s = fold_s ^ din[WIDTH*j +: WIDTH];
        end
    end

    // One Galois step; XNOR mode is the bitwise inverse of the XOR result.
    always_comb begin
        step_s = {sig_r[WIDTH-2:0], 1'b0}
               ^ (sig_r[WIDTH-1] ? POLY : {WIDTH{1'b0}})
               ^ fold_s;
        if (MODE) begin
            next_s = ~step_s;
        end else begin
            next_s = step_s;
        end
    end

    // Signature register; load has priority over a compaction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (load) begin
            sig_r <= SEED;
        end else if (en) begin
            sig_r <= next_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig      = sig_r;
    assign sig_next = next_s;

endmodule

// File: rtl/misr_compactor.sv
// LBIST output evaluator: MISR plus a session controller that counts valid
// response cycles and compares the final signature against a golden value.
module misr_compactor
    import misr_compactor_pkg::*;
#(
    parameter int               WIDTH = 24,
    parameter int               DIN_W = 48,
    parameter logic [WIDTH-1:0] POLY  = 24'h000087,
    parameter logic [WIDTH-1:0] SEED  = 24'd100,
    parameter bit               MODE  = 1'b0,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] n_r;
    logic [WIDTH-1:0] golden_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             load_s;
    logic             en_s;
    logic             last_s;
    logic [WIDTH-1:0] sig_s;
    logic [WIDTH-1:0] sig_next_s;

    // Restart and abort both suppress a compaction step in their cycle.
    always_comb begin
        load_s = start;
        en_s   = (state_r == ST_RUN) && din_valid && !start && !abort;
        last_s = (cnt_r == (n_r - CNT_ONE));
    end

    misr_compactor_core #(
        .WIDTH (WIDTH),
        .DIN_W (DIN_W),
        .POLY  (POLY),
        .SEED  (SEED),
        .MODE  (MODE)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .en       (en_s),
        .din      (din),
        .sig      (sig_s),
        .sig_next (sig_next_s)
    );

    // Session FSM with counter, sampled session parameters and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            n_r      <= {CNT_W{1'b0}};
            golden_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else if (start) begin
            cnt_r    <= {CNT_W{1'b0}};
            n_r      <= n_patterns;
            golden_r <= golden;
            if (n_patterns == {CNT_W{1'b0}}) begin
                // Empty session: the seed itself is the final signature.
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                pass_r  <= (SEED == golden);
            end else begin
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
                pass_r  <= 1'b0;
            end
        end else if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (din_valid) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (last_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (sig_next_s == golden_r);
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sig  = sig_s;
    assign busy = busy_r;
    assign done = done_r;
    assign pass = pass_r;

endmodule

// File: tb/tb_misr_compactor.sv
// Bench for misr_compactor: three instances (seed/mode variants) share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_misr_compactor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  n_patterns;
    logic [7:0]  golden;
    logic        din_valid;
    logic [15:0] din;

    logic [7:0]  sig0, sig1, sig2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        pass0, pass1, pass2;

    misr_compactor #(.WIDTH(8), .DIN_W(16), .POLY(8'h1D), .SEED(8'h80), .MODE(1'b0), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_patterns(n_patterns),
        .golden(golden), .din_valid(din_valid), .din(din),
        .sig(sig0), .busy(busy0), .done(done0), .pass(pass0));

    misr_compactor #(.WIDTH(8), .DIN_W(16), .POLY(8'h1D), .SEED(8'h01), .MODE(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_patterns(n_patterns),
        .golden(golden), .din_valid(din_valid), .din(din),
        .sig(sig1), .busy(busy1), .done(done1), .pass(pass1));

    misr_compactor #(.WIDTH(8), .DIN_W(16), .POLY(8'h1D), .SEED(8'h01), .MODE(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_patterns(n_patterns),
        .golden(golden), .din_valid(din_valid), .din(din),
        .sig(sig2), .busy(busy2), .done(done2), .pass(pass2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, one entry per instance.
    int seed_v [3] = '{128, 1, 1};
    int mode_v [3] = '{0, 0, 1};
    int m_sig  [3];
    int m_cnt  [3];
    int m_n    [3];
    int m_gold [3];
    bit m_busy [3];
    bit m_done [3];
    bit m_pass [3];
    int held;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One MISR step written as plain integer arithmetic on the stated rule.
    function automatic int mstep(input int s, input int d, input int mode);
        int v;
        v = (s * 2) % 256;
        if (s >= 128) v = v ^ 'h1D;
        v = v ^ (d % 256) ^ (d / 256);
        if (mode != 0) v = 255 - v;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sig[i] = seed_v[i]; m_cnt[i] = 0; m_n[i] = 0; m_gold[i] = 0;
            m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_sig[i] = seed_v[i]; m_cnt[i] = 0; m_n[i] = 0; m_gold[i] = 0;
                m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
            end else if (start) begin
                m_sig[i] = seed_v[i]; m_cnt[i] = 0;
                m_n[i] = int'(n_patterns); m_gold[i] = int'(golden);
                m_busy[i] = (n_patterns != 4'd0);
                m_done[i] = (n_patterns == 4'd0);
                m_pass[i] = (n_patterns == 4'd0) && (seed_v[i] == int'(golden));
            end else if (abort) begin
                m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
            end else if (m_busy[i] && din_valid) begin
                m_sig[i] = mstep(m_sig[i], int'(din), mode_v[i]);
                m_cnt[i]++;
                if (m_cnt[i] == m_n[i]) begin
                    m_busy[i] = 0; m_done[i] = 1;
                    m_pass[i] = (m_sig[i] == m_gold[i]);
                end
            end
        end
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ".sig0"}, int'(sig0), m_sig[0]);
        chk({ph, ".sig1"}, int'(sig1), m_sig[1]);
        chk({ph, ".sig2"}, int'(sig2), m_sig[2]);
        chk({ph, ".busy0"}, int'(busy0), int'(m_busy[0]));
        chk({ph, ".busy1"}, int'(busy1), int'(m_busy[1]));
        chk({ph, ".busy2"}, int'(busy2), int'(m_busy[2]));
        chk({ph, ".done0"}, int'(done0), int'(m_done[0]));
        chk({ph, ".done1"}, int'(done1), int'(m_done[1]));
        chk({ph, ".done2"}, int'(done2), int'(m_done[2]));
        chk({ph, ".pass0"}, int'(pass0), int'(m_pass[0]));
        chk({ph, ".pass1"}, int'(pass1), int'(m_pass[1]));
        chk({ph, ".pass2"}, int'(pass2), int'(m_pass[2]));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 16'h0000;
    endtask

    task automatic do_start(input int n, input int g);
        idle_inputs();
        start = 1'b1; n_patterns = n[3:0]; golden = g[7:0];
        step("start");
        start = 1'b0;
    endtask

    task automatic do_valid(input int d);
        idle_inputs();
        din_valid = 1'b1; din = d[15:0];
        step("valid");
        din_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; n_patterns = 4'd0; golden = 8'h00;
        idle_inputs();
        model_reset();
        #12;
        compare_all("reset");
        chk("reset_sig0", int'(sig0), 'h80);
        chk("reset_busy0", int'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // Single pattern, zero response.
        do_start(1, 'h1D);
        do_valid(0);
        chk("t1_sig0", int'(sig0), 'h1D);
        chk("t1_done0", int'(done0), 1);
        chk("t1_pass0", int'(pass0), 1);
        chk("t3_sig2", int'(sig2), 'hFD);

        // XNOR mode compare, matching and non-matching golden.
        do_start(1, 'hFD);
        do_valid(0);
        chk("t3_pass2_hit", int'(pass2), 1);
        do_start(1, 'hFC);
        do_valid(0);
        chk("t3_pass2_miss", int'(pass2), 0);

        // Two patterns, then a response arriving in DONE is ignored.
        do_start(2, 'h04);
        do_valid(0);
        chk("t2_sig1_a", int'(sig1), 'h02);
        do_valid(0);
        chk("t2_sig1_b", int'(sig1), 'h04);
        chk("t2_pass1", int'(pass1), 1);
        do_valid('h0F0F);
        chk("t2_sig1_hold", int'(sig1), 'h04);

        // Valid gaps: exactly three updates over five cycles.
        do_start(3, $urandom_range(255));
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            din_valid = (k == 0 || k >= 3);
            din = 16'($urandom);
            step("t4");
            chk("t4_busy0", int'(busy0), (k < 4) ? 1 : 0);
            chk("t4_done0", int'(done0), (k == 4) ? 1 : 0);
        end

        // Restart mid-run, then abort in DONE.
        do_start(5, 0);
        do_valid('h1234);
        do_start(2, 0);
        chk("t5_restart_sig0", int'(sig0), 'h80);
        chk("t5_restart_busy0", int'(busy0), 1);
        do_valid('h5555);
        do_valid('hA0A0);
        held = m_sig[0];
        idle_inputs(); abort = 1'b1;
        step("abort");
        chk("t5_abort_sig0", int'(sig0), held);
        chk("t5_abort_done0", int'(done0), 0);
        do_start(0, 'h80);
        chk("t6_n0_sig0", int'(sig0), 'h80);
        chk("t6_n0_pass0", int'(pass0), 1);
        idle_inputs(); abort = 1'b1;
        step("abort2");
        chk("t5_abort_pass0", int'(pass0), 0);

        // Start and abort together: start wins.
        idle_inputs(); start = 1'b1; abort = 1'b1; n_patterns = 4'd2; golden = 8'h00;
        step("start_abort");
        chk("both_busy0", int'(busy0), 1);

        // Asynchronous reset in the middle of a session.
        do_start(6, 0);
        do_valid('hBEEF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        chk("async_sig0", int'(sig0), 'h80);
        chk("async_busy0", int'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        // Randomized sessions.
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(11) == 0);
            abort      = ($urandom_range(29) == 0);
            n_patterns = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(4));
            golden     = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
            din_valid  = ($urandom_range(2) != 0);
            din        = 16'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
